// File: rtl/acc_datapath.sv
// acc_datapath
// Execution datapath that sits below the multi-cycle controller. It holds
// two operand registers, a two-input ALU with operand muxes, a registered ALU
// result, a W-bit accumulator and a carry (link) bit. It reports the status
// flags that the controller uses for its skip and branch decisions.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   memdata [W-1:0]     memory read data, source for opnd1 and opnd2
//   pc      [W-1:0]     program counter, ALU A source when Asrc=00
//   Asrc    [1:0]       ALU A select: 00 pc, 01 accp, 10 opnd2, 11 zero
//   Bsrc                ALU B select: 0 constant 1, 1 opnd2
//   op                  ALU op: 0 AND, 1 ADD
//   ld1, ld2            load opnd1 / opnd2 from memdata
//   ldALUnext           load alureg from aluout
//   clearacc, compacc   clear / complement accumulator (clear first)
//   clearcy, compcy     clear / complement carry (clear first)
//   RL, RR              rotate {cy,acc} left / right by one
//   accwrite            load acc from aluout
//   cywrite             toggle cy by the ALU carry-out
//   aluout  [W-1:0]     combinational ALU result
//   alureg  [W-1:0]     registered ALU result
//   opnd1, opnd2        operand registers
//   acc     [W-1:0]     accumulator
//   cyout               carry / link bit
//   accminus, acczero   acc sign bit and acc == 0
//
// Strobes are level signals sampled on each rising clk edge. There is no
// handshake: every strobe that is high at an edge acts in that cycle.
module acc_datapath #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] memdata,
    input  logic [W-1:0] pc,
    input  logic [1:0]   Asrc,
    input  logic         Bsrc,
    input  logic         op,
    input  logic         ld1,
    input  logic         ld2,
    input  logic         ldALUnext,
    input  logic         clearacc,
    input  logic         compacc,
    input  logic         clearcy,
    input  logic         compcy,
    input  logic         RL,
    input  logic         RR,
    input  logic         accwrite,
    input  logic         cywrite,
    output logic [W-1:0] aluout,
    output logic [W-1:0] alureg,
    output logic [W-1:0] opnd1,
    output logic [W-1:0] opnd2,
    output logic [W-1:0] acc,
    output logic         cyout,
    output logic         accminus,
    output logic         acczero
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic         cy;
    logic [W-1:0] accp;
    logic         cyp;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W:0]   sum;
    logic         alu_c;
    logic [W-1:0] acc_next;
    logic         cy_next;

    // Clear and complement are applied before anything else. The ALU sees
    // accp, not raw acc, so a single cycle can do operations such as
    // "clear, complement, increment".
    always_comb begin
        accp = clearacc ? '0 : acc;
        accp = compacc ? ~accp : accp;
        cyp  = clearcy ? 1'b0 : cy;
        cyp  = compcy ? ~cyp : cyp;
    end

    always_comb begin
        alu_a = '0;
        case (Asrc)
            2'b00:   alu_a = pc;
            2'b01:   alu_a = accp;
            2'b10:   alu_a = opnd2;
            default: alu_a = '0;
        endcase
        alu_b = Bsrc ? opnd2 : ONE;
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        if (op) begin
            aluout = sum[W-1:0];
            alu_c  = sum[W];
        end else begin
            aluout = alu_a & alu_b;
            alu_c  = 1'b0;
        end
    end

    // An ALU write takes priority over a rotate. RL and RR together cancel
    // each other, and the clear/complement results are still written.
    always_comb begin
        acc_next = accp;
        cy_next  = cyp;
        if (accwrite || cywrite) begin
            if (accwrite) acc_next = aluout;
            if (cywrite)  cy_next  = cyp ^ alu_c;
        end else if (RL && !RR) begin
            acc_next = {accp[W-2:0], cyp};
            cy_next  = accp[W-1];
        end else if (RR && !RL) begin
            acc_next = {cyp, accp[W-1:1]};
            cy_next  = accp[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opnd1  <= '0;
            opnd2  <= '0;
            alureg <= '0;
            acc    <= '0;
            cy     <= 1'b0;
        end else begin
            if (ld1)       opnd1  <= memdata;
            if (ld2)       opnd2  <= memdata;
            if (ldALUnext) alureg <= aluout;
            acc <= acc_next;
            cy  <= cy_next;
        end
    end

    assign cyout    = cy;
    assign accminus = acc[W-1];
    assign acczero  = (acc == '0);

endmodule

// File: tb/tb_acc_datapath.sv
module tb_acc_datapath;

  localparam int W = 12;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] memdata;
  logic [W-1:0] pc;
  logic [1:0]   Asrc;
  logic         Bsrc;
  logic         op;
  logic         ld1;
  logic         ld2;
  logic         ldALUnext;
  logic         clearacc;
  logic         compacc;
  logic         clearcy;
  logic         compcy;
  logic         RL;
  logic         RR;
  logic         accwrite;
  logic         cywrite;
  logic [W-1:0] aluout;
  logic [W-1:0] alureg;
  logic [W-1:0] opnd1;
  logic [W-1:0] opnd2;
  logic [W-1:0] acc;
  logic         cyout;
  logic         accminus;
  logic         acczero;

  acc_datapath #(.W(W)) dut (
    .clk(clk), .rst(rst), .memdata(memdata), .pc(pc),
    .Asrc(Asrc), .Bsrc(Bsrc), .op(op), .ld1(ld1), .ld2(ld2),
    .ldALUnext(ldALUnext), .clearacc(clearacc), .compacc(compacc),
    .clearcy(clearcy), .compcy(compcy), .RL(RL), .RR(RR),
    .accwrite(accwrite), .cywrite(cywrite), .aluout(aluout),
    .alureg(alureg), .opnd1(opnd1), .opnd2(opnd2), .acc(acc),
    .cyout(cyout), .accminus(accminus), .acczero(acczero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // reference model state
  int m_acc = 0, m_cy = 0, m_op1 = 0, m_op2 = 0, m_alu = 0;

  function automatic int eff_acc();
    int v;
    v = clearacc ? 0 : m_acc;
    if (compacc) v = MASK - v;
    return v;
  endfunction

  function automatic int eff_cy();
    int v;
    v = clearcy ? 0 : m_cy;
    if (compcy) v = 1 - v;
    return v;
  endfunction

  // Returns the ALU result in bits W-1:0 and the carry-out in bit W.
  function automatic int model_alu();
    int a, b;
    case (Asrc)
      2'b00: a = int'(pc);
      2'b01: a = eff_acc();
      2'b10: a = m_op2;
      default: a = 0;
    endcase
    b = Bsrc ? m_op2 : 1;
    if (op) return a + b;
    return a & b;
  endfunction

  always @(posedge clk) begin
    int r, a, c, word;
    r = model_alu();
    a = eff_acc();
    c = eff_cy();
    if (rst) begin
      m_acc = 0; m_cy = 0; m_op1 = 0; m_op2 = 0; m_alu = 0;
    end else begin
      if (ld1) m_op1 = int'(memdata);
      if (ld2) m_op2 = int'(memdata);
      if (ldALUnext) m_alu = r & MASK;
      if (accwrite || cywrite) begin
        m_acc = accwrite ? (r & MASK) : a;
        m_cy  = cywrite ? (c ^ ((r >> W) & 1)) : c;
      end else begin
        // treat {cy,acc} as one W+1 bit word and rotate it
        word = (c << W) | a;
        if (RL && !RR)      word = ((word << 1) | (word >> W)) & ((MASK << 1) | 1);
        else if (RR && !RL) word = (word >> 1) | ((word & 1) << W);
        m_acc = word & MASK;
        m_cy  = word >> W;
      end
    end
  end

  // scoreboard check
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every output against the model on each negedge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("aluout",   aluout, W'(model_alu() & MASK));
      chk("alureg",   alureg, W'(m_alu));
      chk("opnd1",    opnd1,  W'(m_op1));
      chk("opnd2",    opnd2,  W'(m_op2));
      chk("acc",      acc,    W'(m_acc));
      chk("cyout",    W'(cyout),    W'(m_cy));
      chk("accminus", W'(accminus), W'((m_acc >> (W-1)) & 1));
      chk("acczero",  W'(acczero),  W'(m_acc == 0));
    end
  end

  // driver tasks
  task automatic idle();
    rst = 0; ld1 = 0; ld2 = 0; ldALUnext = 0;
    clearacc = 0; compacc = 0; clearcy = 0; compcy = 0;
    RL = 0; RR = 0; accwrite = 0; cywrite = 0;
    Asrc = 2'b11; Bsrc = 0; op = 0;
  endtask

  // apply the current inputs for one cycle, then drop all strobes
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_acc(input logic [W-1:0] v);
    memdata = v; ld2 = 1; tick();
    Asrc = 2'b10; Bsrc = 1; op = 0; accwrite = 1; clearcy = 1; tick();
  endtask

  initial begin
    idle();
    memdata = '0;
    pc = '0;

    // reset with every strobe asserted
    rst = 1; ld1 = 1; ld2 = 1; ldALUnext = 1; clearacc = 1; compacc = 1;
    clearcy = 1; compcy = 1; RL = 1; RR = 1; accwrite = 1; cywrite = 1;
    memdata = 12'hFFF; Asrc = 2'b01; op = 1;
    tick();
    chk_en = 1;
    chk("rst_acc", acc, 12'h000);
    chk("rst_cy", W'(cyout), 12'h000);
    chk("rst_zero", W'(acczero), 12'h001);
    chk("rst_minus", W'(accminus), 12'h000);
    chk("rst_opnd", opnd1 | opnd2 | alureg, 12'h000);

    tick(); tick();  // idle cycles: everything holds

    // load then add
    load_acc(12'h010);
    chk("preload", acc, 12'h010);
    memdata = 12'h0F0; ld2 = 1; tick();
    Asrc = 2'b01; Bsrc = 1; op = 1; accwrite = 1; cywrite = 1; tick();
    chk("add_acc", acc, 12'h100);
    chk("add_cy", W'(cyout), 12'h000);
    chk("add_zero", W'(acczero), 12'h000);

    // carry toggle on wrap
    load_acc(12'hFFF);
    clearcy = 1; compcy = 1; tick();
    chk("set_cy", W'(cyout), 12'h001);
    memdata = 12'h001; ld2 = 1; tick();
    Asrc = 2'b01; Bsrc = 1; op = 1; accwrite = 1; cywrite = 1; tick();
    chk("wrap_acc", acc, 12'h000);
    chk("wrap_cy", W'(cyout), 12'h000);
    chk("wrap_zero", W'(acczero), 12'h001);

    // micro-sequence: clear, complement, increment
    load_acc(12'h123);
    clearacc = 1; compacc = 1; accwrite = 1; Asrc = 2'b01; Bsrc = 0; op = 1;
    #1 chk("micro_alu", aluout, 12'h000);
    tick();
    chk("micro_acc", acc, 12'h000);
    chk("micro_minus", W'(accminus), 12'h000);
    clearacc = 1; compacc = 1; Asrc = 2'b01; Bsrc = 0; op = 1; tick();
    chk("comp_acc", acc, 12'hFFF);
    chk("comp_minus", W'(accminus), 12'h001);

    // rotates
    load_acc(12'h801);
    RL = 1; tick();
    chk("rl_acc", acc, 12'h002);
    chk("rl_cy", W'(cyout), 12'h001);
    RR = 1; tick();
    chk("rr_acc", acc, 12'h801);
    chk("rr_cy", W'(cyout), 12'h000);
    RL = 1; RR = 1; tick();
    chk("rlrr_acc", acc, 12'h801);
    RL = 1; accwrite = 1; Asrc = 2'b11; Bsrc = 0; op = 1; tick();
    chk("rl_aw_acc", acc, 12'h001);
    chk("rl_aw_cy", W'(cyout), 12'h000);
    RL = 1; tick();
    RL = 1; tick();
    chk("rl2_acc", acc, 12'h004);
    clearcy = 1; compcy = 1; RR = 1; tick();
    chk("cmp_rr_acc", acc, 12'h802);

    // AND into acc and alureg
    load_acc(12'h3CC);
    memdata = 12'h0F0; ld2 = 1; tick();
    op = 0; Asrc = 2'b01; Bsrc = 1; accwrite = 1; ldALUnext = 1; tick();
    chk("and_acc", acc, 12'h0C0);
    chk("and_alureg", alureg, 12'h0C0);

    // pc + 1 wraps, carry toggles the link
    pc = 12'hFFF; Asrc = 2'b00; Bsrc = 0; op = 1; cywrite = 1; ldALUnext = 1;
    #1 chk("pc_wrap_alu", aluout, 12'h000);
    tick();
    chk("pc_wrap_cy", W'(cyout), 12'h001);
    pc = 12'h7A5; Asrc = 2'b00; Bsrc = 0; op = 1; ldALUnext = 1; tick();
    chk("pc_inc", alureg, 12'h7A6);

    // both operand loads together
    memdata = 12'h5A5; ld1 = 1; ld2 = 1; tick();
    chk("ld_both1", opnd1, 12'h5A5);
    chk("ld_both2", opnd2, 12'h5A5);
    memdata = 12'h3C3; ld1 = 1; tick();
    chk("ld1_only", opnd1, 12'h3C3);
    chk("ld2_hold", opnd2, 12'h5A5);

    // reset mid-sequence beats every strobe
    load_acc(12'h9AB);
    rst = 1; compacc = 1; compcy = 1; RL = 1; ld1 = 1; ld2 = 1;
    ldALUnext = 1; Asrc = 2'b10; memdata = 12'h777;
    tick();
    chk("mid_rst_acc", acc, 12'h000);
    chk("mid_rst_regs", opnd1 | opnd2 | alureg, 12'h000);
    chk("mid_rst_zero", W'(acczero), 12'h001);
    tick();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
